// File: rtl/pulse_record_reader.sv
// Streams a completed pulse record out of BRAM port B into an AXI-Stream.
// Optional header word enabled by defining PULSE_READER_HEADER_EN.
module pulse_record_reader #(
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        adc_clk,
  input  logic        adc_rst,
  input  logic        pulse_data_valid,
  input  logic [10:0] record_len,
  output logic [12:0] ram_addrb,
  output logic        ram_enb,
  input  logic [31:0] ram_doutb,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        busy,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 2;

`ifdef PULSE_READER_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [10:0] len_q, len_d;
  logic [10:0] word_cnt_q, word_cnt_d;
  logic [12:0] addr_q, addr_d;
  logic enb_q, enb_d;
  logic rlast_q, rlast_d;
  logic ovf_q, ovf_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] lst_q, lst_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [32:0] mem_q [FIFO_DEPTH];

  logic push, pop, hdr_push, credit;
  logic [32:0] push_word, hdr_word;
  logic [OW-1:0] occ;

  assign m_tvalid  = (cnt_q != '0);
  assign m_tdata   = m_tvalid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign m_tlast   = m_tvalid & mem_q[rd_ptr_q][32];
  assign pop       = m_tvalid & m_tready;
  assign ram_enb   = enb_q;
  assign ram_addrb = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign overflow  = ovf_q;
  assign hdr_word  = {record_len == 11'd0, 16'hA55A, 5'b0, record_len};

  // Credit: words buffered + words on the bus/in flight must leave room
  always_comb begin
    occ = OW'(cnt_q) + OW'(enb_q);
    for (int i = 0; i < RD_LATENCY; i++) begin
      occ = occ + OW'(vld_q[i]);
    end
    credit = (occ < OW'(FIFO_DEPTH));
  end

  // Record sequencing: accept strobes, issue reads, wait for the last beat
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    enb_d      = 1'b0;
    rlast_d    = 1'b0;
    hdr_push   = 1'b0;
    ovf_d      = pulse_data_valid & (state_q != ST_IDLE);
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (pulse_data_valid && (HDR_EN || record_len != 11'd0)) begin
          len_d      = record_len;
          word_cnt_d = 11'd0;
          hdr_push   = HDR_EN;
          state_d    = (record_len == 11'd0) ? ST_DRAIN : ST_READ;
        end
      end
      state_q == ST_READ: begin
        if (credit) begin
          enb_d      = 1'b1;
          addr_d     = {word_cnt_q, 2'b00};
          word_cnt_d = word_cnt_q + 11'd1;
          rlast_d    = (word_cnt_q == len_q - 11'd1);
          if (rlast_d) state_d = ST_DRAIN;
        end
      end
      state_q == ST_DRAIN: begin
        if (pop && m_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-return tracking and FIFO pointer bookkeeping
  always_comb begin
    vld_d[0] = enb_q;
    lst_d[0] = rlast_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
    push      = vld_q[RD_LATENCY-1] | hdr_push;
    push_word = hdr_push ? hdr_word
                         : {lst_q[RD_LATENCY-1], ram_doutb};
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
  end

  // State, counters and in-flight pipeline
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      enb_q      <= 1'b0;
      rlast_q    <= 1'b0;
      ovf_q      <= 1'b0;
      vld_q      <= '0;
      lst_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      enb_q      <= enb_d;
      rlast_q    <= rlast_d;
      ovf_q      <= ovf_d;
      vld_q      <= vld_d;
      lst_q      <= lst_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // FIFO storage; occupancy alone decides what is valid
  always_ff @(posedge adc_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

endmodule

// File: tb/tb_pulse_record_reader.sv
// Bench for pulse_record_reader: two instances (read latency 1 and 2)
// share stimulus; each has its own BRAM model and scoreboard queue.
module tb_pulse_record_reader;

`ifdef PULSE_READER_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic rst, strobe, tready;
  logic [10:0] rlen;

  logic [12:0] addr0, addr1;
  logic enb0, enb1;
  logic [31:0] dout0, dout1, p1;
  logic [31:0] td0, td1;
  logic tv0, tv1, tl0, tl1, bsy0, bsy1, ovf0, ovf1;

  always #5 clk = ~clk;

  pulse_record_reader #(.RD_LATENCY(1), .FIFO_DEPTH(4)) u_dut0 (
    .adc_clk(clk), .adc_rst(rst),
    .pulse_data_valid(strobe), .record_len(rlen),
    .ram_addrb(addr0), .ram_enb(enb0), .ram_doutb(dout0),
    .m_tdata(td0), .m_tvalid(tv0), .m_tready(tready),
    .m_tlast(tl0), .busy(bsy0), .overflow(ovf0)
  );

  pulse_record_reader #(.RD_LATENCY(2), .FIFO_DEPTH(8)) u_dut1 (
    .adc_clk(clk), .adc_rst(rst),
    .pulse_data_valid(strobe), .record_len(rlen),
    .ram_addrb(addr1), .ram_enb(enb1), .ram_doutb(dout1),
    .m_tdata(td1), .m_tvalid(tv1), .m_tready(tready),
    .m_tlast(tl1), .busy(bsy1), .overflow(ovf1)
  );

  function automatic logic [31:0] ram_word(input logic [12:0] a);
    return 32'hC0DE0000 + {21'b0, a[12:2]};
  endfunction

  always @(posedge clk) begin
    if (enb0) dout0 <= ram_word(addr0);
  end

  always @(posedge clk) begin
    if (enb1) p1 <= ram_word(addr1);
    dout1 <= p1;
  end

  typedef struct {
    int          len;
    bit          rnd;
    logic [31:0] last_word;
    logic [12:0] last_addr;
  } vec_t;

  vec_t vecs [5];
  int depth [2] = '{4, 8};

  int n_checks = 0;
  int n_fail = 0;
  bit rnd_mode = 1'b0;

  logic [32:0] expq [2][$];
  int beats [2];
  int ovf_cnt [2];
  int outs [2];
  logic [12:0] exp_addr [2];
  logic [31:0] last_data [2];
  logic [12:0] last_addr [2];
  bit prev_stall [2];
  logic [31:0] prev_data [2];
  logic prev_last [2];
  bit last_hs [2];

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h", nm, k, act, exp);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      beats[k] = 0;
      ovf_cnt[k] = 0;
      exp_addr[k] = '0;
      last_data[k] = '0;
      last_addr[k] = '0;
    end
  endtask

  task automatic monitor();
    logic [31:0] td [2];
    logic tv [2], tl [2], bs [2], ov [2], en [2];
    logic [12:0] ad [2];
    logic [32:0] e;
    td = '{td0, td1}; tv = '{tv0, tv1}; tl = '{tl0, tl1};
    bs = '{bsy0, bsy1}; ov = '{ovf0, ovf1};
    en = '{enb0, enb1}; ad = '{addr0, addr1};
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        expq[k].delete();
        outs[k] = 0;
        prev_stall[k] = 1'b0;
        last_hs[k] = 1'b0;
        beats[k] = 0;
        continue;
      end
      if (prev_stall[k]) begin
        chk("stall_valid", k, 32'(tv[k]), 32'd1);
        chk("stall_data", k, td[k], prev_data[k]);
        chk("stall_last", k, 32'(tl[k]), 32'(prev_last[k]));
      end
      if (last_hs[k]) chk("busy_fall", k, 32'(bs[k]), 32'd0);
      last_hs[k] = 1'b0;
      if (ov[k]) ovf_cnt[k]++;
      if (en[k]) begin
        chk("credit", k, 32'(outs[k] < depth[k]), 32'd1);
        chk("addr", k, 32'(ad[k]), 32'(exp_addr[k]));
        exp_addr[k] = exp_addr[k] + 13'd4;
        last_addr[k] = ad[k];
        outs[k]++;
      end
      if (tv[k] && tready) begin
        beats[k]++;
        if (td[k][31:16] != 16'hA55A) outs[k]--;
        if (expq[k].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat dut%0d: got %h, expected none",
                   k, td[k]);
        end else begin
          e = expq[k].pop_front();
          chk("tdata", k, td[k], e[31:0]);
          chk("tlast", k, 32'(tl[k]), 32'(e[32]));
        end
        if (tl[k]) begin
          last_data[k] = td[k];
          last_hs[k] = 1'b1;
          chk("busy_at_last", k, 32'(bs[k]), 32'd1);
        end
      end
      prev_stall[k] = tv[k] & ~tready;
      prev_data[k] = td[k];
      prev_last[k] = tl[k];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_exp(input int len);
    for (int k = 0; k < 2; k++) begin
`ifdef PULSE_READER_HEADER_EN
      expq[k].push_back({len == 0, 16'hA55A, 5'b0, 11'(len)});
`endif
      for (int n = 0; n < len; n++) begin
        expq[k].push_back({n == len - 1, 32'hC0DE0000 + 32'(n)});
      end
    end
  endtask

  task automatic start_rec(input int len, input bit acc);
    strobe = 1'b1;
    rlen = 11'(len);
    if (acc) begin
      clear_stats();
      push_exp(len);
    end
    tick();
    strobe = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!bsy0 && !bsy1 && expq[0].size() == 0 &&
          expq[1].size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk({nm, "_timeout"}, 0, 32'(done), 32'd1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_enb"}, 0, 32'(enb0), 0);
    chk({nm, "_enb"}, 1, 32'(enb1), 0);
    chk({nm, "_addr"}, 0, 32'(addr0), 0);
    chk({nm, "_addr"}, 1, 32'(addr1), 0);
    chk({nm, "_tvalid"}, 0, 32'(tv0), 0);
    chk({nm, "_tvalid"}, 1, 32'(tv1), 0);
    chk({nm, "_tdata"}, 0, td0, 0);
    chk({nm, "_tdata"}, 1, td1, 0);
    chk({nm, "_tlast"}, 0, 32'(tl0), 0);
    chk({nm, "_tlast"}, 1, 32'(tl1), 0);
    chk({nm, "_busy"}, 0, 32'(bsy0), 0);
    chk({nm, "_busy"}, 1, 32'(bsy1), 0);
    chk({nm, "_ovf"}, 0, 32'(ovf0), 0);
    chk({nm, "_ovf"}, 1, 32'(ovf1), 0);
  endtask

  initial begin
    vecs[0] = '{8,    1'b0, 32'hC0DE0007, 13'h001C};
    vecs[1] = '{16,   1'b1, 32'hC0DE000F, 13'h003C};
    vecs[2] = '{1,    1'b0, 32'hC0DE0000, 13'h0000};
    vecs[3] = '{3,    1'b1, 32'hC0DE0002, 13'h0008};
    vecs[4] = '{2047, 1'b0, 32'hC0DE07FE, 13'h1FF8};

    rst = 1'b1;
    strobe = 1'b0;
    rlen = '0;
    tready = 1'b1;
    clear_stats();
    repeat (3) tick();
    chk_reset_outs("reset");
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      rnd_mode = vecs[v].rnd;
      start_rec(vecs[v].len, 1'b1);
      wait_done("vec", vecs[v].len * 8 + 100);
      rnd_mode = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
        chk("vec_beats", k, 32'(beats[k]), 32'(vecs[v].len + HDR));
        chk("vec_last_word", k, last_data[k], vecs[v].last_word);
        chk("vec_last_addr", k, 32'(last_addr[k]),
            32'(vecs[v].last_addr));
        chk("vec_no_ovf", k, 32'(ovf_cnt[k]), 32'd0);
      end
    end

    start_rec(5, 1'b1);
    repeat (2) tick();
    start_rec(7, 1'b0);
    wait_done("ovf", 200);
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      chk("ovf_pulses", k, 32'(ovf_cnt[k]), 32'd1);
      chk("ovf_beats", k, 32'(beats[k]), 32'(5 + HDR));
    end

    start_rec(10, 1'b1);
    for (int i = 0; i < 100 && beats[0] < 3; i++) tick();
    chk("rst_trigger", 0, 32'(beats[0] >= 3), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_outs("abort");
    rst = 1'b0;
    repeat (6) tick();
    start_rec(2, 1'b1);
    wait_done("post_rst", 200);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_beats", k, 32'(beats[k]), 32'(2 + HDR));
    end

`ifdef PULSE_READER_HEADER_EN
    start_rec(3, 1'b1);
    wait_done("hdr3", 200);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("hdr3_beats", k, 32'(beats[k]), 32'd4);
    end
    start_rec(0, 1'b1);
    wait_done("hdr0", 200);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("hdr0_beats", k, 32'(beats[k]), 32'd1);
      chk("hdr0_word", k, last_data[k], 32'hA55A0000);
    end
`else
    clear_stats();
    start_rec(0, 1'b0);
    chk("len0_busy", 0, 32'(bsy0), 32'd0);
    chk("len0_busy", 1, 32'(bsy1), 32'd0);
    repeat (8) tick();
    for (int k = 0; k < 2; k++) begin
      chk("len0_ovf", k, 32'(ovf_cnt[k]), 32'd0);
      chk("len0_beats", k, 32'(beats[k]), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
